// File: rtl/a0_ctrl_pkg.sv
// Shared types and constants for the a0 control sequencer: FSM states,
// command mode encodings and the bit positions of the datapath strobes.
package a0_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SUB  = 3'd2,
        ST_COPY = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] MODE_LOAD = 2'd0;
    localparam logic [1:0] MODE_SUBN = 2'd1;
    localparam logic [1:0] MODE_SUBZ = 2'd2;
    localparam logic [1:0] MODE_COPY = 2'd3;

    // Positions of the one-hot datapath strobes in the internal strobe vector
    localparam int STB_CTRL1 = 0;
    localparam int STB_CTRL5 = 1;
    localparam int STB_CTRL6 = 2;
    localparam int STB_W     = 3;

endpackage

// File: rtl/a0_iter_counter.sv
// Iteration counter for the SUB phase: synchronous clear, increment and an
// equality flag against the latched subtraction limit.
module a0_iter_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             eq
);

    logic [WIDTH-1:0] value_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_reg <= '0;
        end else if (clr) begin
            value_reg <= '0;
        end else if (inc) begin
            value_reg <= value_reg + 1'b1;
        end
    end

    // The FSM never increments once eq is set, so the count cannot wrap
    assign eq    = (value_reg == limit);
    assign value = value_reg;

endmodule

// File: rtl/a0_ctrl_sequencer.sv
// Turns a one-cycle start/mode command into the CTRL1/CTRL5/CTRL6 strobe
// sequence for the a0/a1 datapath, looping on its a0 status flags.
module a0_ctrl_sequencer
    import a0_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] count,
    input  logic             a0_zero,
    input  logic             a0_neg,
    output logic             CTRL1,
    output logic             CTRL5,
    output logic             CTRL6,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] iter
);

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] count_reg;
    logic [STB_W-1:0] strobe;
    logic             iter_clr, iter_inc, iter_eq;
    logic             accept;
    logic             sub_stop;

    assign accept = (state_reg == ST_IDLE) && start;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            mode_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                mode_reg  <= mode;
                count_reg <= count;
            end
        end
    end

    a0_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (iter_clr),
        .inc   (iter_inc),
        .limit (count_reg),
        .value (iter),
        .eq    (iter_eq)
    );

    // The a0 flags come straight off the datapath register, so the SUB exit
    // decision is a register-to-output path with no loop through CTRL5.
    assign sub_stop = iter_eq ||
                      ((mode_reg == MODE_SUBZ) && (a0_zero || a0_neg));

    always_comb begin
        state_next = state_reg;
        strobe     = '0;
        iter_clr   = 1'b0;
        iter_inc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    iter_clr   = 1'b1;
                    state_next = (mode == MODE_COPY) ? ST_COPY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                strobe[STB_CTRL1] = 1'b1;
                state_next = (mode_reg == MODE_LOAD) ? ST_DONE : ST_SUB;
            end
            ST_SUB: begin
                if (sub_stop) begin
                    state_next = ST_COPY;
                end else begin
                    strobe[STB_CTRL5] = 1'b1;
                    iter_inc          = 1'b1;
                end
            end
            ST_COPY: begin
                strobe[STB_CTRL6] = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign CTRL1 = strobe[STB_CTRL1];
    assign CTRL5 = strobe[STB_CTRL5];
    assign CTRL6 = strobe[STB_CTRL6];
    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_a0_ctrl_sequencer.sv
// Bench for a0_ctrl_sequencer: drives it against a small a0/a1 datapath
// model (sub = 2) and checks each command against an arithmetic reference.
module tb_a0_ctrl_sequencer;

    localparam int LIMIT = 70000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] count = 16'd0;
    logic        a0_zero, a0_neg;
    logic        CTRL1, CTRL5, CTRL6, busy, done;
    logic [15:0] iter;

    logic [15:0] dp_a0 = 16'd0;
    logic [15:0] dp_a1 = 16'd0;
    logic [15:0] reg_in = 16'd0;
    logic [15:0] ref_a0 = 16'd0;
    logic [15:0] ref_a1 = 16'd0;

    int tests = 0;
    int fails = 0;

    a0_ctrl_sequencer #(.WIDTH(16)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .start   (start),
        .mode    (mode),
        .count   (count),
        .a0_zero (a0_zero),
        .a0_neg  (a0_neg),
        .CTRL1   (CTRL1),
        .CTRL5   (CTRL5),
        .CTRL6   (CTRL6),
        .busy    (busy),
        .done    (done),
        .iter    (iter)
    );

    always #5 CLK = ~CLK;

    // Datapath stand-in: keeps its contents across sequencer reset
    always @(posedge CLK) begin
        if (CTRL1)      dp_a0 <= reg_in;
        else if (CTRL5) dp_a0 <= dp_a0 - 16'd2;
        if (CTRL6)      dp_a1 <= dp_a0;
    end
    assign a0_zero = (dp_a0 == 16'd0);
    assign a0_neg  = dp_a0[15];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle
    task automatic run_cmd(input string name, input logic [1:0] m, input logic [15:0] cnt,
                           input logic [15:0] rin, input bit poke);
        int k, cyc, n1, n5, n6, ndone, done_at, excl_bad;
        int exp_busy;
        k = 0; cyc = 0; n1 = 0; n5 = 0; n6 = 0; ndone = 0; done_at = -1; excl_bad = 0;
        if (m != 2'd3) begin
            ref_a0 = rin;
            if (m != 2'd0) begin
                while (k < int'(cnt) && (m == 2'd1 || (ref_a0 != 16'd0 && ref_a0 < 16'h8000))) begin
                    ref_a0 = ref_a0 - 16'd2;
                    k++;
                end
            end
        end
        if (m != 2'd0) ref_a1 = ref_a0;
        exp_busy = (m == 2'd0 || m == 2'd3) ? 2 : k + 4;

        reg_in = rin;
        start  = 1'b1;
        mode   = m;
        count  = cnt;
        @(negedge CLK);
        start = 1'b0;
        mode  = 2'($urandom);
        count = 16'($urandom);
        while (busy === 1'b1 && cyc < LIMIT) begin
            cyc++;
            n1 += int'(CTRL1);
            n5 += int'(CTRL5);
            n6 += int'(CTRL6);
            if (int'(CTRL1) + int'(CTRL5) + int'(CTRL6) > 1) excl_bad++;
            if (done === 1'b1) begin
                ndone++;
                done_at = cyc;
            end
            if (poke && cyc == 2) begin
                start = 1'b1;
                mode  = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        check({name, ".busy_cycles"}, 32'(cyc), 32'(exp_busy));
        check({name, ".done_pulses"}, 32'(ndone), 32'd1);
        check({name, ".done_last"}, 32'(done_at), 32'(cyc));
        check({name, ".ctrl1"}, 32'(n1), (m == 2'd3) ? 32'd0 : 32'd1);
        check({name, ".ctrl5"}, 32'(n5), 32'(k));
        check({name, ".ctrl6"}, 32'(n6), (m == 2'd0) ? 32'd0 : 32'd1);
        check({name, ".exclusive"}, 32'(excl_bad), 32'd0);
        check({name, ".iter"}, 32'(iter), 32'(k));
        check({name, ".a0"}, 32'(dp_a0), 32'(ref_a0));
        check({name, ".a1"}, 32'(dp_a1), 32'(ref_a1));
        $display("[TB] %s mode=%0d count=%0d rin=%0d busy=%0d strobes=%0d iter=%0d a0=%0d a1=%0d",
                 name, m, cnt, rin, cyc, n5, iter, dp_a0, dp_a1);
    endtask

    initial begin
        logic [1:0]  rm;
        logic [15:0] rc, rr;

        repeat (2) @(negedge CLK);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.iter", 32'(iter), 32'd0);
        check("reset.ctrl", 32'({CTRL1, CTRL5, CTRL6}), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        run_cmd("load",      2'd0, 16'd0,     16'd4620, 1'b0);
        run_cmd("subn5",     2'd1, 16'd5,     16'd4620, 1'b0);
        run_cmd("subz_zero", 2'd2, 16'hFFFF,  16'd4620, 1'b0);
        run_cmd("subz_lim",  2'd2, 16'd3,     16'd4620, 1'b0);
        run_cmd("subz_neg",  2'd2, 16'hFFFF,  16'd5,    1'b0);
        run_cmd("subn0",     2'd1, 16'd0,     16'd77,   1'b0);
        run_cmd("copy",      2'd3, 16'd9,     16'd1,    1'b0);
        run_cmd("poke",      2'd1, 16'd4,     16'd100,  1'b1);
        @(negedge CLK);
        check("poke.idle_after", 32'(busy), 32'd0);

        // Reset in the middle of a long mode-2 run
        reg_in = 16'd4620;
        start  = 1'b1;
        mode   = 2'd2;
        count  = 16'hFFFF;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(done), 32'd0);
        check("rst_mid.ctrl", 32'({CTRL1, CTRL5, CTRL6}), 32'd0);
        check("rst_mid.iter", 32'(iter), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_mid.idle", 32'(busy), 32'd0);
        ref_a0 = dp_a0;
        run_cmd("after_rst", 2'd0, 16'd0, 16'd321, 1'b0);

        for (int i = 0; i < 20; i++) begin
            rm = 2'($urandom_range(0, 3));
            rc = 16'($urandom_range(0, 30));
            rr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 80)) : 16'($urandom);
            if (rm == 2'd2 && rr < 16'd80 && $urandom_range(0, 2) == 0) rc = 16'hFFFF;
            run_cmd($sformatf("rand%0d", i), rm, rc, rr, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
